// File: rtl/tag_compare_stage_if.sv
// Lookup-side bundle for tag_compare_stage: request handshake, tag array read path
// and the registered response handshake.
interface tag_compare_stage_if #(
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned TAG_BITS   = 22,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned WAY_BITS   = 2
);
  logic                         req_valid;
  logic                         req_ready;
  logic [TAG_BITS-1:0]          req_tag;
  logic [INDEX_BITS-1:0]        req_index;
  logic [WAY_BITS-1:0]          req_pred_way;
  logic [INDEX_BITS-1:0]        lookup_index;
  logic [NUM_WAYS*TAG_BITS-1:0] way_tags;
  logic [NUM_WAYS-1:0]          way_valid;
  logic                         resp_valid;
  logic                         resp_ready;
  logic                         resp_hit;
  logic [WAY_BITS-1:0]          resp_way;
  logic                         resp_pred_ok;
  logic                         resp_multi_hit;
  logic [INDEX_BITS-1:0]        resp_index;
  logic [TAG_BITS-1:0]          resp_tag;

  modport master (
    output req_valid, req_tag, req_index, req_pred_way, way_tags, way_valid, resp_ready,
    input  req_ready, lookup_index, resp_valid, resp_hit, resp_way, resp_pred_ok,
           resp_multi_hit, resp_index, resp_tag
  );

  modport slave (
    input  req_valid, req_tag, req_index, req_pred_way, way_tags, way_valid, resp_ready,
    output req_ready, lookup_index, resp_valid, resp_hit, resp_way, resp_pred_ok,
           resp_multi_hit, resp_index, resp_tag
  );
endinterface

// File: rtl/tag_compare_stage.sv
// Registered L1D tag compare stage: per-way tag match, hit way select, way-predictor
// verdict over a valid/ready handshake, plus saturating lookup/hit/pred_ok counters.
module tag_compare_stage #(
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned TAG_BITS   = 22,
  parameter int unsigned INDEX_BITS = $clog2(NUM_SETS),
  parameter int unsigned WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int unsigned CNT_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tag_compare_stage_if.slave   bus,
  input  logic                 cnt_clear,
  output logic [CNT_BITS-1:0]  cnt_lookups,
  output logic [CNT_BITS-1:0]  cnt_hits,
  output logic [CNT_BITS-1:0]  cnt_pred_ok
);

  logic                  req_ready;
  logic                  accept;
  logic [NUM_WAYS-1:0]   match;
  logic                  hit_d;
  logic [WAY_BITS-1:0]   way_d;
  logic                  multi_d;
  logic                  pred_ok_d;

  logic                  resp_valid_q;
  logic                  resp_hit_q;
  logic [WAY_BITS-1:0]   resp_way_q;
  logic                  resp_pred_ok_q;
  logic                  resp_multi_hit_q;
  logic [INDEX_BITS-1:0] resp_index_q;
  logic [TAG_BITS-1:0]   resp_tag_q;

  logic [CNT_BITS-1:0]   cnt_lookups_q;
  logic [CNT_BITS-1:0]   cnt_hits_q;
  logic [CNT_BITS-1:0]   cnt_pred_ok_q;

  assign req_ready        = !resp_valid_q || bus.resp_ready;
  assign accept           = bus.req_valid && req_ready;
  assign bus.req_ready    = req_ready;
  assign bus.lookup_index = bus.req_index;

  always_comb begin
    match     = '0;
    way_d     = '0;
    hit_d     = 1'b0;
    multi_d   = 1'b0;
    pred_ok_d = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      match[w] = bus.way_valid[w] && (bus.way_tags[w*TAG_BITS +: TAG_BITS] == bus.req_tag);
    end
    // Scan from the top down so the lowest-numbered matching way is the last write.
    for (int unsigned w = NUM_WAYS; w > 0; w--) begin
      if (match[w-1]) begin
        way_d = WAY_BITS'(w - 1);
      end
    end
    hit_d     = |match;
    multi_d   = (match & (match - NUM_WAYS'(1))) != '0;
    pred_ok_d = hit_d && (way_d == bus.req_pred_way);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q     <= 1'b0;
      resp_hit_q       <= 1'b0;
      resp_way_q       <= '0;
      resp_pred_ok_q   <= 1'b0;
      resp_multi_hit_q <= 1'b0;
      resp_index_q     <= '0;
      resp_tag_q       <= '0;
    end else if (accept) begin
      resp_valid_q     <= 1'b1;
      resp_hit_q       <= hit_d;
      resp_way_q       <= way_d;
      resp_pred_ok_q   <= pred_ok_d;
      resp_multi_hit_q <= multi_d;
      resp_index_q     <= bus.req_index;
      resp_tag_q       <= bus.req_tag;
    end else if (bus.resp_ready) begin
      resp_valid_q     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lookups_q <= '0;
      cnt_hits_q    <= '0;
      cnt_pred_ok_q <= '0;
    end else if (cnt_clear) begin
      cnt_lookups_q <= '0;
      cnt_hits_q    <= '0;
      cnt_pred_ok_q <= '0;
    end else if (accept) begin
      if (cnt_lookups_q != '1) cnt_lookups_q <= cnt_lookups_q + CNT_BITS'(1);
      if (hit_d && cnt_hits_q != '1) cnt_hits_q <= cnt_hits_q + CNT_BITS'(1);
      if (pred_ok_d && cnt_pred_ok_q != '1) cnt_pred_ok_q <= cnt_pred_ok_q + CNT_BITS'(1);
    end
  end

  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_hit       = resp_hit_q;
  assign bus.resp_way       = resp_way_q;
  assign bus.resp_pred_ok   = resp_pred_ok_q;
  assign bus.resp_multi_hit = resp_multi_hit_q;
  assign bus.resp_index     = resp_index_q;
  assign bus.resp_tag       = resp_tag_q;
  assign cnt_lookups        = cnt_lookups_q;
  assign cnt_hits           = cnt_hits_q;
  assign cnt_pred_ok        = cnt_pred_ok_q;

endmodule

// File: tb/tb_tag_compare_stage.sv
// Bench for tag_compare_stage: directed lookups checked every cycle against a
// spec-level model, plus literal expectations at key points.
module tb_tag_compare_stage;
  localparam int unsigned NW   = 4;
  localparam int unsigned TB   = 22;
  localparam int unsigned IB   = 6;
  localparam int unsigned WB   = 2;
  localparam int unsigned CB   = 4;
  localparam int          MAXC = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_clear = 1'b0;
  logic [CB-1:0] cnt_lookups, cnt_hits, cnt_pred_ok;

  int n_checks = 0;
  int n_fail   = 0;

  tag_compare_stage_if #(.NUM_WAYS(NW), .TAG_BITS(TB), .INDEX_BITS(IB), .WAY_BITS(WB)) bus ();

  tag_compare_stage #(
    .NUM_SETS(64), .NUM_WAYS(NW), .TAG_BITS(TB), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clear(cnt_clear),
    .cnt_lookups(cnt_lookups), .cnt_hits(cnt_hits), .cnt_pred_ok(cnt_pred_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic          hit;
    logic [WB-1:0] way;
    logic          multi;
    logic          pok;
  } res_t;

  function automatic res_t lookup(input logic [NW*TB-1:0] tags, input logic [NW-1:0] vld,
                                  input logic [TB-1:0] tag, input logic [WB-1:0] pred);
    int   q[$];
    res_t r;
    for (int w = 0; w < NW; w++)
      if (vld[w] && tags[w*TB +: TB] == tag) q.push_back(w);
    r.hit   = (q.size() > 0);
    r.way   = r.hit ? WB'(q[0]) : '0;
    r.multi = (q.size() > 1);
    r.pok   = r.hit && (q[0] == int'(pred));
    return r;
  endfunction

  res_t          cur;
  logic          m_acc;
  logic          m_valid = 1'b0;
  res_t          m_res;
  logic [IB-1:0] m_index;
  logic [TB-1:0] m_tag;
  int            m_lk = 0, m_ht = 0, m_po = 0;

  assign cur   = lookup(bus.way_tags, bus.way_valid, bus.req_tag, bus.req_pred_way);
  assign m_acc = bus.req_valid && (!m_valid || bus.resp_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_res <= '0; m_index <= '0; m_tag <= '0;
      m_lk <= 0; m_ht <= 0; m_po <= 0;
    end else begin
      if (m_acc) begin
        m_valid <= 1'b1; m_res <= cur; m_index <= bus.req_index; m_tag <= bus.req_tag;
      end else if (bus.resp_ready) begin
        m_valid <= 1'b0;
      end
      if (cnt_clear) begin
        m_lk <= 0; m_ht <= 0; m_po <= 0;
      end else if (m_acc) begin
        if (m_lk < MAXC) m_lk <= m_lk + 1;
        if (cur.hit && m_ht < MAXC) m_ht <= m_ht + 1;
        if (cur.pok && m_po < MAXC) m_po <= m_po + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_resp_valid", 32'(bus.resp_valid), 32'(m_valid));
    chk("m_cnt_lookups", 32'(cnt_lookups), 32'(m_lk));
    chk("m_cnt_hits", 32'(cnt_hits), 32'(m_ht));
    chk("m_cnt_pred_ok", 32'(cnt_pred_ok), 32'(m_po));
    if (rst_n) begin
      chk("m_req_ready", 32'(bus.req_ready), 32'(!m_valid || bus.resp_ready));
      chk("m_lookup_index", 32'(bus.lookup_index), 32'(bus.req_index));
      if (m_valid) begin
        chk("m_resp_hit", 32'(bus.resp_hit), 32'(m_res.hit));
        chk("m_resp_way", 32'(bus.resp_way), 32'(m_res.way));
        chk("m_resp_multi", 32'(bus.resp_multi_hit), 32'(m_res.multi));
        chk("m_resp_pred_ok", 32'(bus.resp_pred_ok), 32'(m_res.pok));
        chk("m_resp_index", 32'(bus.resp_index), 32'(m_index));
        chk("m_resp_tag", 32'(bus.resp_tag), 32'(m_tag));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_way(input int w, input logic [TB-1:0] tag);
    bus.way_tags[w*TB +: TB] = tag;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_tag = '0; bus.req_index = '0; bus.req_pred_way = '0;
    bus.way_tags = '0; bus.way_valid = '0; bus.resp_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_cnt_lookups", 32'(cnt_lookups), 32'd0);

    // Hit with correct prediction
    set_way(2, 22'h12345); bus.way_valid = 4'b0100;
    bus.req_tag = 22'h12345; bus.req_index = 6'd5; bus.req_pred_way = 2'd2; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    chk("t1_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("t1_resp_hit", 32'(bus.resp_hit), 32'd1);
    chk("t1_resp_way", 32'(bus.resp_way), 32'd2);
    chk("t1_resp_pred_ok", 32'(bus.resp_pred_ok), 32'd1);
    chk("t1_cnts", {cnt_lookups, cnt_hits, cnt_pred_ok}, 32'h111);

    // Async reset while a response is held
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("async_rst_cnt", 32'(cnt_lookups), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Wrong prediction then miss, back to back
    bus.req_pred_way = 2'd0; bus.req_valid = 1'b1;
    step();
    chk("t2_hit", 32'(bus.resp_hit), 32'd1);
    chk("t2_pred_ok", 32'(bus.resp_pred_ok), 32'd0);
    bus.way_valid = 4'b0000;
    step();
    bus.req_valid = 1'b0;
    chk("t2_miss_hit", 32'(bus.resp_hit), 32'd0);
    chk("t2_miss_way", 32'(bus.resp_way), 32'd0);
    chk("t2_cnts", {cnt_lookups, cnt_hits, cnt_pred_ok}, 32'h210);
    step();

    // Backpressure
    bus.resp_ready = 1'b0;
    bus.req_tag = 22'h0AAAA; bus.req_index = 6'd7; bus.req_valid = 1'b1;
    step();
    chk("bp_a_valid", 32'(bus.resp_valid), 32'd1);
    bus.req_tag = 22'h0BBBB; bus.req_index = 6'd9;
    set_way(0, 22'h0BBBB); bus.way_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      step();
      chk("bp_hold_tag", 32'(bus.resp_tag), 32'h0AAAA);
      chk("bp_hold_hit", 32'(bus.resp_hit), 32'd0);
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    chk("bp_b_tag", 32'(bus.resp_tag), 32'h0BBBB);
    chk("bp_b_index", 32'(bus.resp_index), 32'd9);
    chk("bp_b_hit", 32'(bus.resp_hit), 32'd1);
    step();
    chk("drain_valid", 32'(bus.resp_valid), 32'd0);

    // Multi-hit
    set_way(1, 22'h3C0DE); set_way(3, 22'h3C0DE); bus.way_valid = 4'b1010;
    bus.req_tag = 22'h3C0DE; bus.req_pred_way = 2'd3; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    chk("mh_hit", 32'(bus.resp_hit), 32'd1);
    chk("mh_way", 32'(bus.resp_way), 32'd1);
    chk("mh_multi", 32'(bus.resp_multi_hit), 32'd1);
    chk("mh_pred_ok", 32'(bus.resp_pred_ok), 32'd0);
    step();

    // Counter saturation and clear priority
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    bus.way_valid = 4'b0000; bus.req_valid = 1'b1;
    for (int i = 0; i < MAXC; i++) step();
    chk("sat_reach", 32'(cnt_lookups), 32'd15);
    step();
    chk("sat_hold", 32'(cnt_lookups), 32'd15);
    set_way(2, 22'h12345); bus.way_valid = 4'b0100;
    bus.req_tag = 22'h12345; bus.req_pred_way = 2'd2; cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0; bus.req_valid = 1'b0;
    chk("clr_cnts", {cnt_lookups, cnt_hits, cnt_pred_ok}, 32'h000);
    chk("clr_resp_hit", 32'(bus.resp_hit), 32'd1);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
